// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: payload and pipeline-control bundle for one stage-boundary register
interface pipe_stage_reg_if #(parameter int WIDTH = 64);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             stall;
    logic             bubble;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    modport master (output in_data, in_valid, stall, bubble, input out_data, out_valid);
    modport slave (input in_data, in_valid, stall, bubble, output out_data, out_valid);
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: Y86-64 pipeline register with stall/bubble control, event counters, stall watchdog and sticky error flags
module pipe_stage_reg #(
    parameter int               WIDTH      = 64,
    parameter logic [WIDTH-1:0] RST_VAL    = '0,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0,
    parameter int               CNT_W      = 16,
    parameter int               MAX_STALL  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_stage_reg_if.slave   bus,
    input  logic              cnt_clr,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_run,
    output logic              wdog_err,
    output logic              ctl_err
);
    localparam logic [CNT_W-1:0] MAX_RUN = CNT_W'(MAX_STALL);
    logic [CNT_W-1:0] stall_cnt_nxt, bubble_cnt_nxt, run_nxt;
    logic             ctl_hit, wdog_hit;
    // next counter values: cnt_clr discards this cycle's event, counters saturate at all-ones
    always_comb begin
        stall_cnt_nxt  = cnt_clr ? '0 : (bus.stall && stall_cnt != '1) ? stall_cnt + 1'b1 : stall_cnt;
        bubble_cnt_nxt = cnt_clr ? '0 : (!bus.stall && bus.bubble && bubble_cnt != '1) ? bubble_cnt + 1'b1 : bubble_cnt;
        run_nxt        = (cnt_clr || !bus.stall) ? '0 : (stall_run == '1) ? stall_run : stall_run + 1'b1;
        ctl_hit        = bus.stall & bus.bubble;
        wdog_hit       = run_nxt == MAX_RUN;
    end
    // payload register: stall holds, bubble injects a nop, otherwise load upstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_data  <= RST_VAL;
            bus.out_valid <= 1'b0;
        end else if (!bus.stall) begin
            bus.out_data  <= bus.bubble ? BUBBLE_VAL : bus.in_data;
            bus.out_valid <= bus.bubble ? 1'b0 : bus.in_valid;
        end
    end
    // event counters and sticky flags; a new error on the clearing edge keeps its flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            stall_run  <= '0;
            wdog_err   <= 1'b0;
            ctl_err    <= 1'b0;
        end else begin
            stall_cnt  <= stall_cnt_nxt;
            bubble_cnt <= bubble_cnt_nxt;
            stall_run  <= run_nxt;
            wdog_err   <= wdog_hit | (wdog_err & ~err_clr);
            ctl_err    <= ctl_hit | (ctl_err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg (CNT_W=3, MAX_STALL=4)
module tb_pipe_stage_reg;
    localparam int WIDTH = 16;
    localparam logic [WIDTH-1:0] RST_V = 16'h0F0F;
    localparam logic [WIDTH-1:0] BUB_V = 16'h00B0;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cnt_clr = 1'b0;
    logic err_clr = 1'b0;
    logic [2:0] stall_cnt, bubble_cnt, stall_run;
    logic wdog_err, ctl_err;
    int vectors = 0;
    int errs = 0;
    pipe_stage_reg_if #(.WIDTH(WIDTH)) bus ();
    pipe_stage_reg #(
        .WIDTH(WIDTH), .RST_VAL(RST_V), .BUBBLE_VAL(BUB_V), .CNT_W(3), .MAX_STALL(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .cnt_clr(cnt_clr), .err_clr(err_clr),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .stall_run(stall_run),
        .wdog_err(wdog_err), .ctl_err(ctl_err)
    );
    always #5 clk = ~clk;
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_all(input string tag, input logic [15:0] d, input logic v,
                           input logic [2:0] sc, input logic [2:0] bc, input logic [2:0] sr,
                           input logic we, input logic ce);
        chk({tag, ".data"}, 64'(bus.out_data), 64'(d));
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'(v));
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(sc));
        chk({tag, ".bubble_cnt"}, 64'(bubble_cnt), 64'(bc));
        chk({tag, ".stall_run"}, 64'(stall_run), 64'(sr));
        chk({tag, ".wdog_err"}, 64'(wdog_err), 64'(we));
        chk({tag, ".ctl_err"}, 64'(ctl_err), 64'(ce));
    endtask
    initial begin
        bus.in_data = 16'hDEAD;
        bus.in_valid = 1'b1;
        bus.stall = 1'b0;
        bus.bubble = 1'b0;
        tick(2);
        chk_all("reset", RST_V, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        bus.in_data = 16'h1234;
        tick(1);
        chk_all("load1", 16'h1234, 1, 0, 0, 0, 0, 0);
        bus.in_data = 16'h5678;
        tick(1);
        chk_all("load2", 16'h5678, 1, 0, 0, 0, 0, 0);
        bus.in_data = 16'h00AA;
        tick(1);
        chk("load_aa", 64'(bus.out_data), 64'h00AA);
        bus.stall = 1'b1;
        bus.in_data = 16'h00BB;
        tick(3);
        chk_all("stall3", 16'h00AA, 1, 3, 0, 3, 0, 0);
        bus.stall = 1'b0;
        tick(1);
        chk_all("unstall", 16'h00BB, 1, 3, 0, 0, 0, 0);
        bus.bubble = 1'b1;
        bus.in_data = 16'hCCCC;
        tick(2);
        chk_all("bubble2", BUB_V, 0, 3, 2, 0, 0, 0);
        bus.bubble = 1'b0;
        tick(1);
        chk_all("unbubble", 16'hCCCC, 1, 3, 2, 0, 0, 0);
        bus.stall = 1'b1;
        bus.bubble = 1'b1;
        bus.in_data = 16'h1111;
        tick(1);
        chk_all("conflict", 16'hCCCC, 1, 4, 2, 1, 0, 1);
        bus.bubble = 1'b0;
        tick(2);
        chk_all("run3", 16'hCCCC, 1, 6, 2, 3, 0, 1);
        tick(1);
        chk_all("wdog", 16'hCCCC, 1, 7, 2, 4, 1, 1);
        bus.stall = 1'b0;
        bus.in_data = 16'hDDDD;
        tick(1);
        chk_all("sticky", 16'hDDDD, 1, 7, 2, 0, 1, 1);
        err_clr = 1'b1;
        tick(1);
        chk_all("err_clr", 16'hDDDD, 1, 7, 2, 0, 0, 0);
        bus.stall = 1'b1;
        bus.bubble = 1'b1;
        tick(1);
        chk_all("set_wins", 16'hDDDD, 1, 7, 2, 1, 0, 1);
        err_clr = 1'b0;
        bus.bubble = 1'b0;
        cnt_clr = 1'b1;
        tick(1);
        chk_all("cnt_clr", 16'hDDDD, 1, 0, 0, 0, 0, 1);
        cnt_clr = 1'b0;
        tick(10);
        chk_all("sat10", 16'hDDDD, 1, 7, 0, 7, 1, 1);
        cnt_clr = 1'b1;
        tick(1);
        chk_all("clr_in_stall", 16'hDDDD, 1, 0, 0, 0, 1, 1);
        cnt_clr = 1'b0;
        bus.stall = 1'b0;
        bus.bubble = 1'b1;
        tick(9);
        chk_all("bub_sat", BUB_V, 0, 0, 7, 0, 1, 1);
        bus.bubble = 1'b0;
        bus.stall = 1'b1;
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", RST_V, 0, 0, 0, 0, 0, 0);
        tick(1);
        rst_n = 1'b1;
        bus.stall = 1'b0;
        bus.in_data = 16'h7777;
        bus.in_valid = 1'b1;
        tick(1);
        chk_all("post_rst", 16'h7777, 1, 0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
